ps2_key_encoder: RTL and testbench

//  Device-to-host PS/2 keyboard receiver that produces the 11-bit ps2_key event word consumed by the top-level control decoder.

---
 rtl/ps2_key_encoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//   Device-to-host PS/2 keyboard receiver. Deframes serial bytes clocked by the
//   keyboard, strips E0 (extended) and F0 (break) prefixes, swallows the E1
//   pause sequence and protocol replies, and emits an 11-bit key event word.
//   Event word: [10] toggles per event, [9] pressed, [8] extended, [7:0] code.
// Ports
//   clock        in   system clock, only clock of the block
//   reset        in   asynchronous active-high reset, synchronous release
//   ps2_clk      in   raw PS/2 clock pin (asynchronous)
//   ps2_data     in   raw PS/2 data pin (asynchronous)
//   ps2_key      out  event word, held between events
//   rx_byte      out  last good frame byte
//   rx_valid     out  1-cycle strobe, rx_byte updated
//   frame_error  out  1-cycle strobe, frame discarded (start/parity/stop/timeout)
module ps2_key_encoder #(
  parameter int CLK_HZ     = 48_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_error
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          fall;
  logic          data_bit;

  assign data_bit = data_sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      timer_q       <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      skip_q        <= '0;
      key_q         <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      clk_sync_q    <= {clk_sync_q[0], ps2_clk};
      data_sync_q   <= {data_sync_q[0], ps2_data};
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      timer_q       <= timer_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      skip_q        <= skip_d;
      key_q         <= key_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path infers a latch.
    state_d       = state_q;
    filt_clk_d    = filt_clk_q;
    filt_cnt_d    = '0;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    timer_d       = timer_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    skip_d        = skip_q;
    key_d         = key_q;
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    // Glitch filter: the synced clock must disagree for FILTER_LEN
    // consecutive cycles before the filtered level flips.
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) filt_clk_d = clk_sync_q[1];
      else                         filt_cnt_d = filt_cnt_q + FW'(1);
    end
    fall = filt_clk_q & ~filt_clk_d;

    if (state_q == S_IDLE || fall)   timer_d = '0;
    else if (timer_q != TIMEOUT_MAX) timer_d = timer_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        // A fall with data high is not a start bit; it is silently ignored.
        if (fall && !data_bit) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          parity_d = data_bit;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          // Odd parity: data plus parity bit must XOR to 1.
          if (data_bit && (^{shift_q, parity_q})) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
            if (skip_q != 3'd0) begin
              skip_d = skip_q - 3'd1;
            end else if (shift_q == 8'hE1) begin
              // Pause key: E1 plus seven more bytes carry no key event.
              skip_d = 3'd7;
              ext_d  = 1'b0;
              brk_d  = 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
              ext_d = 1'b0;
              brk_d = 1'b0;
            end else begin
              key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            frame_error_d = 1'b1;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fall on the expiry cycle wins, so the timeout only applies without one.
    if (state_q != S_IDLE && !fall && timer_q == TIMEOUT_MAX) begin
      state_d       = S_IDLE;
      frame_error_d = 1'b1;
      ext_d         = 1'b0;
      brk_d         = 1'b0;
    end
  end

  assign ps2_key     = key_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Testbench for ps2_key_encoder: table-driven frames, hand sequences for
// timeout, glitch and reset corner cases, then random frames against a
// byte-level reference model.
module tb_ps2_key_encoder;

  localparam int FILTER_LEN = 8;
  localparam int HALF       = 15;   // PS/2 half bit period, in system clocks
  localparam int GAP        = 30;   // idle cycles between frames

  logic        clock = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_error;

  // Scaled timing: 1 MHz x 200 us gives a 200-cycle timeout.
  ps2_key_encoder #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FILTER_LEN(FILTER_LEN)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int rv_cyc = 0;
  int fall_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid) begin
      n_valid++;
      rv_cyc = cyc;
    end
    if (frame_error) n_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clock_bit(input logic d);
    ps2_data = d;
    wait_cycles(HALF);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    clock_bit(1'b0);
    for (int i = 0; i < 8; i++) clock_bit(b[i]);
    clock_bit(~(^b) ^ bad_par);
    clock_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cycles(GAP);
  endtask

  // Byte-level reference model of the event word.
  logic [10:0] m_key;
  logic        m_ext, m_brk;
  int          m_skip;

  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      case (b)
        8'hE1: begin m_skip = 7; m_ext = 1'b0; m_brk = 1'b0; end
        8'hE0: m_ext = 1'b1;
        8'hF0: m_brk = 1'b1;
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin m_ext = 1'b0; m_brk = 1'b0; end
        default: begin
          m_key = {~m_key[10], ~m_brk, m_ext, b};
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      endcase
    end
  endtask

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        bad_stop;
    int          exp_valid;
    int          exp_err;
    logic [10:0] exp_key;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    logic [7:0] specials [9];
    logic [7:0] b;
    logic bp, bs;
    int r;

    specials = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[3]  = '{8'h75, 1'b0, 1'b0, 1, 0, 11'h175};
    tbl[4]  = '{8'h29, 1'b1, 1'b0, 0, 1, 11'h175};
    tbl[5]  = '{8'h29, 1'b0, 1'b0, 1, 0, 11'h629};
    tbl[6]  = '{8'hFA, 1'b0, 1'b0, 1, 0, 11'h629};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 1, 0, 11'h629};
    tbl[8]  = '{8'h12, 1'b0, 1'b1, 0, 1, 11'h629};
    tbl[9]  = '{8'h12, 1'b0, 1'b0, 1, 0, 11'h212};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 1, 0, 11'h212};
    tbl[11] = '{8'hAA, 1'b0, 1'b0, 1, 0, 11'h212};
    tbl[12] = '{8'h1C, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[13] = '{8'hE1, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[14] = '{8'h14, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[15] = '{8'h77, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[16] = '{8'hE1, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[17] = '{8'hF0, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[18] = '{8'h14, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[19] = '{8'hF0, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[20] = '{8'h77, 1'b0, 1'b0, 1, 0, 11'h61C};
    tbl[21] = '{8'h4D, 1'b0, 1'b0, 1, 0, 11'h24D};
    tbl[22] = '{8'hE0, 1'b0, 1'b0, 1, 0, 11'h24D};
    tbl[23] = '{8'hF0, 1'b0, 1'b0, 1, 0, 11'h24D};
    tbl[24] = '{8'hFF, 1'b0, 1'b0, 1, 0, 11'h24D};
    tbl[25] = '{8'h5A, 1'b0, 1'b0, 1, 0, 11'h65A};

    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    check("reset_ps2_key", ps2_key, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_error", frame_error, 0);
    reset = 1'b0;
    wait_cycles(10);

    // Table-driven frames.
    for (int i = 0; i < NVEC; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop);
      check($sformatf("tbl%0d_valid", i), n_valid - v0, tbl[i].exp_valid);
      check($sformatf("tbl%0d_err", i), n_err - e0, tbl[i].exp_err);
      check($sformatf("tbl%0d_key", i), ps2_key, tbl[i].exp_key);
      if (tbl[i].exp_valid == 1) check($sformatf("tbl%0d_byte", i), rx_byte, tbl[i].code);
      if (i == 0) check("latency_stop_fall_to_valid", rv_cyc - fall_cyc, FILTER_LEN + 2);
    end

    // Timeout: start plus three data bits, then the keyboard goes silent.
    e0 = n_err;
    v0 = n_valid;
    clock_bit(1'b0);
    clock_bit(1'b1);
    clock_bit(1'b0);
    clock_bit(1'b1);
    ps2_data = 1'b1;
    wait_cycles(150 - HALF);
    check("timeout_not_early", n_err - e0, 0);
    wait_cycles(110);
    check("timeout_err", n_err - e0, 1);
    check("timeout_no_valid", n_valid - v0, 0);
    check("timeout_key_kept", ps2_key, 11'h65A);
    send_frame(8'h16, 1'b0, 1'b0);
    check("after_timeout_key", ps2_key, 11'h216);

    // Short low glitches on ps2_clk while idle.
    v0 = n_valid;
    e0 = n_err;
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(GAP);
    ps2_clk = 1'b0;
    wait_cycles(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cycles(GAP);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_no_err", n_err - e0, 0);
    // A full-length fall with data high is not a start bit.
    ps2_clk = 1'b0;
    wait_cycles(FILTER_LEN + 4);
    ps2_clk = 1'b1;
    wait_cycles(GAP);
    check("idle_fall_data_high_no_err", n_err - e0, 0);
    send_frame(8'hFA, 1'b0, 1'b0);
    check("glitch_fa_valid", n_valid - v0, 1);
    check("glitch_fa_key", ps2_key, 11'h216);

    // Reset in the middle of a pause sequence, mid-byte.
    send_frame(8'hE1, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    v0 = n_valid;
    e0 = n_err;
    clock_bit(1'b0);
    clock_bit(1'b1);
    clock_bit(1'b1);
    reset = 1'b1;
    wait_cycles(3);
    check("midreset_key", ps2_key, 0);
    reset = 1'b0;
    ps2_data = 1'b1;
    wait_cycles(GAP);
    check("midreset_no_valid", n_valid - v0, 0);
    check("midreset_no_err", n_err - e0, 0);
    send_frame(8'h4D, 1'b0, 1'b0);
    check("midreset_4d_key", ps2_key, 11'h64D);

    // Random frames against the reference model.
    m_key  = 11'h64D;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) b = specials[$urandom_range(0, 8)];
      else       b = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 19);
      bp = (r == 0);
      bs = (r == 1);
      v0 = n_valid;
      e0 = n_err;
      send_frame(b, bp, bs);
      model_frame(b, !(bp || bs));
      check($sformatf("rnd%0d_valid", i), n_valid - v0, (bp || bs) ? 0 : 1);
      check($sformatf("rnd%0d_err", i), n_err - e0, (bp || bs) ? 1 : 0);
      check($sformatf("rnd%0d_key", i), ps2_key, m_key);
      if (!(bp || bs)) check($sformatf("rnd%0d_byte", i), rx_byte, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
